calc_ctrl: RTL and testbench
============================

CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 2, cycles calc_string is held before calc_res is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1  controller accepts requester N this cycle.
REQ-006 req0_op / req1_op  input  2  00 add, 01 sub (A-B), 10 OR, 11 negate A (B ignored).
REQ-007 req0_a, req0_b / req1_a, req1_b  input  4 each  operands.
REQ-008 req0_acc / req1_acc  input  1  replace A with accumulator (see Configuration).
REQ-009 calc_string  output  14  datapath command: [13:12] op, [11:8] A, [7:4] B, [3:0] driven 0.
REQ-010 calc_res  input  4  datapath result.
REQ-011 calc_seg  input  7  datapath seven-segment pattern.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer takes response.
REQ-014 rsp_id  output  1  requester that issued the response.
REQ-015 rsp_res  output  4 / rsp_seg  output  7  captured result and segment pattern.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, SETTLE, RESP.
REQ-018 In IDLE, reqN_ready SHALL be high only for the arbitration winner; both low in all other states.
REQ-019 Arbitration SHALL be round-robin: with one valid, that requester wins; with both valid, the requester not granted last wins; last_grant resets to 1 so req0 wins the first tie.
REQ-020 On acceptance (valid & ready) at edge T, calc_string SHALL be loaded at T with {op, A, B, 4'b0}, SETTLE counter loaded, last_grant updated, state -> SETTLE.
REQ-021 SETTLE SHALL last exactly SETTLE_CYCLES cycles; on its final edge calc_res, calc_seg and the winner id SHALL be captured into rsp_res, rsp_seg, rsp_id, rsp_valid set, state -> RESP.
REQ-022 rsp_valid SHALL therefore rise SETTLE_CYCLES edges after the accepting edge.
REQ-023 In RESP, rsp_* SHALL be held stable until rsp_valid & rsp_ready; on that edge rsp_valid clears and state -> IDLE; no new request is accepted in the same cycle.
REQ-024 calc_string SHALL hold its last value outside SETTLE (no glitching between transactions).
REQ-025 Arithmetic SHALL be 4-bit modulo 16 as performed by the datapath; the controller SHALL not modify calc_res.
REQ-026 A requester dropping valid before ready SHALL not be granted; no request is queued.

Reset
REQ-027 While rst is high: state IDLE, calc_string 0, rsp_valid 0, rsp_id 0, rsp_res 0, rsp_seg 0, busy 0, req ready outputs 0, last_grant 1, accumulator 0.
REQ-028 Reset mid-transaction SHALL abort it; no response for it SHALL ever appear.

Configuration
REQ-029 Macro CALC_CTRL_ACC_EN defined: a 4-bit accumulator SHALL load rsp_res on each response capture; an accepted request with reqN_acc=1 SHALL use the accumulator as A.
REQ-030 Macro CALC_CTRL_ACC_EN undefined: no accumulator register; reqN_acc ports SHALL remain present and be ignored; A always from reqN_a.

Verification
REQ-031 After reset, req0 op=00 a=9 b=8, SETTLE_CYCLES=2 -> calc_string=14'h0980, rsp_valid 2 edges after accept, rsp_res=1, rsp_id=0.
REQ-032 req0 and req1 valid continuously, rsp_ready=1 -> grant order 0,1,0,1 over four transactions.
REQ-033 rsp_valid high, rsp_ready low 5 cycles, req1_valid high -> rsp_* stable, req1_ready stays 0, busy=1.
REQ-034 rst pulsed during SETTLE -> all outputs 0 asynchronously, no rsp_valid afterward until a new acceptance.
REQ-035 op=11 a=5 -> rsp_res=11; op=01 a=2 b=5 -> rsp_res=13; op=10 a=9 b=6 -> rsp_res=15.
REQ-036 With CALC_CTRL_ACC_EN: op=00 a=3 b=4 -> 7, then acc=1 op=01 a=0 b=2 -> 5; without macro the second gives 14.

Source files
------------

// File: rtl/calc_ctrl.sv
// Calculator controller: round-robin arbitration of two requesters onto one datapath,
// settle-then-sample, and a held response. Optional accumulator: define CALC_CTRL_ACC_EN.
module calc_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [3:0]  req0_a,
  input  logic [3:0]  req0_b,
  input  logic        req0_acc,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [3:0]  req1_a,
  input  logic [3:0]  req1_b,
  input  logic        req1_acc,
  output logic [13:0] calc_string,
  input  logic [3:0]  calc_res,
  input  logic [6:0]  calc_seg,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [3:0]  rsp_res,
  output logic [6:0]  rsp_seg,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends on anything but state, valids and last grant, and valid is not
  // required to stay high until ready.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic       last_grant_q;
  logic       cur_id_q;
  logic       grant0, grant1;
  logic       accept, capture, win_id;
  logic [1:0] sel_op;
  logic [3:0] sel_a, sel_b, eff_a;
  logic       sel_acc;

  // last_grant = 1 means req1 was served last, so req0 wins the next tie.
  assign grant0 = req0_valid & (~req1_valid | last_grant_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    win_id     = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = grant0 & ~rst;
        req1_ready = grant1 & ~rst;
        accept     = req0_ready | req1_ready;
        win_id     = req1_ready;
        if (accept) state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel_op  = win_id ? req1_op  : req0_op;
  assign sel_a   = win_id ? req1_a   : req0_a;
  assign sel_b   = win_id ? req1_b   : req0_b;
  assign sel_acc = win_id ? req1_acc : req0_acc;

`ifdef CALC_CTRL_ACC_EN
  logic [3:0] acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= 4'd0;
    else if (capture) acc_q <= calc_res;
  end

  assign eff_a = sel_acc ? acc_q : sel_a;
`else
  logic unused_acc;
  assign unused_acc = sel_acc;
  assign eff_a      = sel_a;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      cur_id_q     <= 1'b0;
      calc_string  <= 14'd0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_res      <= 4'd0;
      rsp_seg      <= 7'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        calc_string  <= {sel_op, eff_a, sel_b, 4'b0000};
        cnt_q        <= SETTLE_LOAD;
        last_grant_q <= win_id;
        cur_id_q     <= win_id;
      end else if (state_q == SETTLE && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (capture) begin
        rsp_res   <= calc_res;
        rsp_seg   <= calc_seg;
        rsp_id    <= cur_id_q;
        rsp_valid <= 1'b1;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl: directed vector table, hand-written corner sequences,
// and randomized transactions against a transaction-level reference model.
module tb_calc_ctrl;

  localparam int SETTLE = 2;
`ifdef CALC_CTRL_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_acc;
  logic [1:0]  req0_op;
  logic [3:0]  req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_acc;
  logic [1:0]  req1_op;
  logic [3:0]  req1_a, req1_b;
  logic [13:0] calc_string;
  logic [3:0]  calc_res;
  logic [6:0]  calc_seg;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [3:0]  rsp_res;
  logic [6:0]  rsp_seg;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int last_m   = 1;
  int acc_m    = 0;
  logic [3:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  calc_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_acc(req0_acc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_acc(req1_acc),
    .calc_string(calc_string), .calc_res(calc_res), .calc_seg(calc_seg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_seg(rsp_seg), .busy(busy), .dbg_state(dbg_state)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: seg_of = 7'h3F; 4'h1: seg_of = 7'h06; 4'h2: seg_of = 7'h5B; 4'h3: seg_of = 7'h4F;
      4'h4: seg_of = 7'h66; 4'h5: seg_of = 7'h6D; 4'h6: seg_of = 7'h7D; 4'h7: seg_of = 7'h07;
      4'h8: seg_of = 7'h7F; 4'h9: seg_of = 7'h6F; 4'hA: seg_of = 7'h77; 4'hB: seg_of = 7'h7C;
      4'hC: seg_of = 7'h39; 4'hD: seg_of = 7'h5E; 4'hE: seg_of = 7'h79; default: seg_of = 7'h71;
    endcase
  endfunction

  // Stand-in for the external datapath, driven purely by calc_string.
  always_comb begin
    case (calc_string[13:12])
      2'b00:   calc_res = calc_string[11:8] + calc_string[7:4];
      2'b01:   calc_res = calc_string[11:8] - calc_string[7:4];
      2'b10:   calc_res = calc_string[11:8] | calc_string[7:4];
      default: calc_res = ~calc_string[11:8] + 4'd1;
    endcase
  end
  assign calc_seg = seg_of(calc_res);

  // ---------------- reference model ----------------
  function automatic int model_res(input int op, input int a, input int b);
    case (op)
      0:       model_res = (a + b) % 16;
      1:       model_res = (a - b + 16) % 16;
      2:       model_res = a | b;
      default: model_res = (16 - a) % 16;
    endcase
  endfunction

  function automatic int model_winner();
    if (req0_valid && req1_valid) model_winner = (last_m == 1) ? 0 : 1;
    else                          model_winner = req1_valid ? 1 : 0;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last_m = 1; acc_m = 0;
  endtask

  task automatic set_req(input int id, input int op, input int a, input int b, input int acc);
    if (id == 0) begin
      req0_valid = 1'b1; req0_op = 2'(op); req0_a = 4'(a); req0_b = 4'(b); req0_acc = 1'(acc);
    end else begin
      req1_valid = 1'b1; req1_op = 2'(op); req1_a = 4'(a); req1_b = 4'(b); req1_acc = 1'(acc);
    end
  endtask

  // Runs one transaction from the currently driven valids to the response handshake.
  task automatic complete_txn(input int hold, input bit poke1, output int got);
    int k, win, op_s, a_s, b_s, acc_s, a_eff, exp_r, exp_cs, bad;
    got = -1;
    #1;
    k = 0;
    while (!(req0_ready || req1_ready) && k < 20) begin @(posedge clk); #1; k++; end
    check("ready_wait", int'(k < 20), 1);
    if (k >= 20) begin req0_valid = 1'b0; req1_valid = 1'b0; return; end
    win = model_winner();
    check("grant_id", req1_ready ? 1 : 0, win);
    check("ready_onehot", int'(req0_ready & req1_ready), 0);
    op_s  = win ? req1_op  : req0_op;
    a_s   = win ? req1_a   : req0_a;
    b_s   = win ? req1_b   : req0_b;
    acc_s = win ? req1_acc : req0_acc;
    a_eff = (ACC_EN && acc_s) ? acc_m : a_s;
    exp_r = model_res(op_s, a_eff, b_s);
    exp_cs = op_s * 4096 + a_eff * 256 + b_s * 16;
    exp_q.push_back(4'(exp_r));
    last_m = win;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("calc_string", calc_string, exp_cs);
    check("busy_settle", busy, 1);
    k = 0;
    while (!rsp_valid && k < 40) begin @(posedge clk); #1; k++; end
    check("settle_latency", k, SETTLE);
    check("rsp_res", rsp_res, exp_q.pop_front());
    check("rsp_seg", rsp_seg, seg_of(4'(exp_r)));
    check("rsp_id", rsp_id, win);
    got = rsp_res;
    if (poke1) req1_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      bad = 0;
      if (rsp_valid !== 1'b1 || rsp_res !== 4'(exp_r) || rsp_id !== 1'(win)) bad = 1;
      if (rsp_seg !== seg_of(4'(exp_r)) || calc_string !== 14'(exp_cs)) bad = 1;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) bad = 1;
      check("resp_hold_stable", bad, 0);
    end
    acc_m = exp_r;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_clear", rsp_valid, 0);
    check("idle_after_resp", busy, 0);
    if (poke1) begin
      check("ready_after_release", req1_ready, 1);
      req1_valid = 1'b0;
      bad = 0;
      repeat (3) begin @(posedge clk); #1; if (busy !== 1'b0) bad = 1; end
      check("dropped_valid_not_granted", bad, 0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int id; int op; int a; int b; int exp;
  } vec_t;
  vec_t tab[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, bad, g;
    tab[0] = '{0, 0, 9, 8, 1};
    tab[1] = '{0, 3, 5, 0, 11};
    tab[2] = '{1, 1, 2, 5, 13};
    tab[3] = '{0, 2, 9, 6, 15};
    tab[4] = '{1, 0, 15, 1, 0};
    tab[5] = '{1, 3, 0, 7, 0};
    tab[6] = '{0, 1, 0, 1, 15};
    tab[7] = '{1, 2, 7, 8, 15};

    // reset values while rst is held, with a request pending
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 2'd0; req0_a = 4'd0; req0_b = 4'd0; req0_acc = 1'b0;
    req1_valid = 1'b0; req1_op = 2'd0; req1_a = 4'd0; req1_b = 4'd0; req1_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready0", req0_ready, 0);
    check("rst_calc_string", calc_string, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_fields", {rsp_id, rsp_res, rsp_seg}, 0);
    check("rst_busy", busy, 0);
    do_reset();

    // table-driven directed vectors
    for (int t = 0; t < 8; t++) begin
      set_req(tab[t].id, tab[t].op, tab[t].a, tab[t].b, 0);
      complete_txn(t % 3, 1'b0, got);
      check($sformatf("vec%0d_res", t), got, tab[t].exp);
    end

    // response held under backpressure while the other requester waits
    set_req(0, 1, 2, 5, 0);
    complete_txn(5, 1'b1, got);
    check("backpressure_res", got, 13);

    // round-robin with both requesters valid and the consumer always ready
    do_reset();
    set_req(0, 0, 1, 2, 0);
    set_req(1, 2, 4, 1, 0);
    rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = 0;
      while (!(req0_ready || req1_ready) && k < 20) begin @(posedge clk); #1; k++; end
      g = req1_ready ? 1 : 0;
      check("rr_order", g, i % 2);
      check("rr_model", g, model_winner());
      last_m = g;
      @(posedge clk); #1;
      k = 0;
      while (!rsp_valid && k < 40) begin @(posedge clk); #1; k++; end
      check("rr_rsp_id", rsp_id, g);
      check("rr_rsp_res", rsp_res, g ? 5 : 3);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #1;

    // asynchronous reset in the middle of SETTLE aborts the transaction
    do_reset();
    set_req(0, 0, 1, 1, 0);
    #1;
    check("abort_ready", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check("abort_busy", busy, 1);
    #3 rst = 1'b1; req1_valid = 1'b1;
    #1;
    check("abort_calc_string", calc_string, 0);
    check("abort_busy_low", busy, 0);
    check("abort_outputs", {rsp_valid, rsp_id, rsp_res, rsp_seg, req0_ready, req1_ready}, 0);
    @(posedge clk); #1;
    rst = 1'b0; req1_valid = 1'b0; last_m = 1; acc_m = 0;
    bad = 0;
    repeat (6) begin @(posedge clk); #1; if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1; end
    check("abort_no_response", bad, 0);

    // randomized transactions against the model
    for (int r = 0; r < 30; r++) begin
      int p;
      p = $urandom_range(1, 3);
      req0_op = 2'($urandom_range(0, 3)); req0_a = 4'($urandom_range(0, 15));
      req0_b = 4'($urandom_range(0, 15)); req0_acc = 1'($urandom_range(0, 1));
      req1_op = 2'($urandom_range(0, 3)); req1_a = 4'($urandom_range(0, 15));
      req1_b = 4'($urandom_range(0, 15)); req1_acc = 1'($urandom_range(0, 1));
      req0_valid = p[0]; req1_valid = p[1];
      complete_txn($urandom_range(0, 3), 1'b0, got);
    end

    // accumulator chaining
    do_reset();
    set_req(0, 0, 3, 4, 0);
    complete_txn(0, 1'b0, got);
    check("acc_first", got, 7);
    set_req(0, 1, 0, 2, 1);
    complete_txn(0, 1'b0, got);
    check("acc_second", got, ACC_EN ? 5 : 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
